safe_cmd_parser: RTL and testbench



---
 rtl/safe_pkg.sv | 24 ++
 rtl/dec_accum.sv | 36 +++
 rtl/safe_cmd_parser.sv | 142 ++++++++++++++
 tb/tb_safe_cmd_parser.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/safe_pkg.sv
// rtl/safe_pkg.sv - shared constants and types for the safe-dial datapath
package safe_pkg;

  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  localparam logic DIR_LEFT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    SKIP   = 2'd2,
    DONE   = 2'd3
  } parser_state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

endpackage

// File: rtl/dec_accum.sv
// rtl/dec_accum.sv - decimal accumulator (acc = acc*10 + digit) with overflow detect
module dec_accum #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         step_i,
  input  logic [3:0]   digit_i,
  output logic [W-1:0] acc_o,
  output logic [W-1:0] next_o,
  output logic         ovf_o
);

  localparam logic [W+3:0] TEN = (W+4)'(10);

  logic [W-1:0] acc_q;
  logic [W+3:0] prod;

  // Four guard bits hold the worst case (2^W-1)*10+9 without wrapping.
  assign prod   = ({4'b0000, acc_q} * TEN) + {{W{1'b0}}, digit_i};
  assign ovf_o  = |prod[W+3:W];
  assign next_o = prod[W-1:0];
  assign acc_o  = acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (step_i && !ovf_o) begin
      acc_q <= prod[W-1:0];
    end
  end

endmodule

// File: rtl/safe_cmd_parser.sv
// rtl/safe_cmd_parser.sv - ASCII "L68\n"-style line parser emitting dial command pulses
module safe_cmd_parser
  import safe_pkg::*;
#(
  parameter int unsigned STEPS_W = 32,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned ERR_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               cmd_valid,
  output logic               cmd_dir,
  output logic [STEPS_W-1:0] cmd_steps,
  output logic [CNT_W-1:0]   cmd_count,
  output logic [ERR_W-1:0]   err_count,
  output logic               done
);

  parser_state_e state_q, state_d;
  logic dir_q, dir_d;
  logic seen_q, seen_d;
  logic cmd_valid_q, cmd_dir_q, done_q;
  logic [STEPS_W-1:0] cmd_steps_q;
  logic [CNT_W-1:0]   cmd_count_q;
  logic [ERR_W-1:0]   err_count_q;

  logic xfer, is_dig;
  logic acc_clear, acc_step, acc_ovf, err, emit;
  logic [STEPS_W-1:0] acc_val, acc_next, emit_steps;

  assign in_ready = (state_q != DONE);
  assign xfer     = in_valid & in_ready;
  assign is_dig   = is_digit(in_data);

  dec_accum #(.W(STEPS_W)) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clear_i (acc_clear),
    .step_i  (acc_step),
    .digit_i (in_data[3:0]),
    .acc_o   (acc_val),
    .next_o  (acc_next),
    .ovf_o   (acc_ovf)
  );

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    seen_d     = seen_q;
    acc_clear  = 1'b0;
    acc_step   = 1'b0;
    err        = 1'b0;
    emit       = 1'b0;
    emit_steps = acc_val;
    if (xfer) begin
      case (state_q)
        IDLE: begin
          if (in_data == CH_L || in_data == CH_R) begin
            dir_d     = (in_data == CH_L) ? DIR_LEFT : ~DIR_LEFT;
            acc_clear = 1'b1;
            seen_d    = 1'b0;
            state_d   = DIGITS;
          end else if (in_data != CH_LF && in_data != CH_CR) begin
            err     = 1'b1;
            state_d = SKIP;
          end
        end
        DIGITS: begin
          if (is_dig) begin
            if (acc_ovf) begin
              err     = 1'b1;
              state_d = SKIP;
            end else begin
              acc_step = 1'b1;
              seen_d   = 1'b1;
            end
          end else if (in_data == CH_LF) begin
            emit    = seen_q;
            err     = !seen_q;
            state_d = IDLE;
          end else if (in_data != CH_CR) begin
            err     = 1'b1;
            state_d = SKIP;
          end
        end
        SKIP: begin
          if (in_data == CH_LF) state_d = IDLE;
        end
        default: ;
      endcase
      // The final byte acts as an implicit newline for an unfinished line.
      if (in_last) begin
        if (state_d == DIGITS) begin
          emit = emit | seen_d;
          err  = err | !seen_d;
        end
        state_d = DONE;
      end
    end
    if (acc_step) emit_steps = acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      seen_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_dir_q   <= 1'b0;
      cmd_steps_q <= '0;
      cmd_count_q <= '0;
      err_count_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      seen_q      <= seen_d;
      cmd_valid_q <= emit;
      if (emit) begin
        cmd_dir_q   <= dir_d;
        cmd_steps_q <= emit_steps;
        cmd_count_q <= cmd_count_q + CNT_W'(1);
      end
      if (err && (err_count_q != {ERR_W{1'b1}})) begin
        err_count_q <= err_count_q + ERR_W'(1);
      end
      if (xfer && in_last) done_q <= 1'b1;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_dir   = cmd_dir_q;
  assign cmd_steps = cmd_steps_q;
  assign cmd_count = cmd_count_q;
  assign err_count = err_count_q;
  assign done      = done_q;

endmodule

// File: tb/tb_safe_cmd_parser.sv
// tb/tb_safe_cmd_parser.sv - scoreboard bench for safe_cmd_parser
module tb_safe_cmd_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        cmd_valid;
  logic        cmd_dir;
  logic [31:0] cmd_steps;
  logic [31:0] cmd_count;
  logic [15:0] err_count;
  logic        done;

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];
  int dial_pos   = 50;
  int dial_zeros = 0;

  always #5 clk = ~clk;

  safe_cmd_parser #(.STEPS_W(32), .CNT_W(32), .ERR_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .cmd_valid (cmd_valid),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .cmd_count (cmd_count),
    .err_count (err_count),
    .done      (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every command pulse is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && cmd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_cmd actual=dir%0d/%0d required=none", cmd_dir, cmd_steps);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("cmd_dir", 64'(cmd_dir), 64'(e[32]));
        check("cmd_steps", 64'(cmd_steps), 64'(e[31:0]));
      end
      dial_pos = (dial_pos + (cmd_dir ? -int'(cmd_steps % 100) : int'(cmd_steps % 100)) + 100) % 100;
      if (dial_pos == 0) dial_zeros++;
    end
  end

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_str(input string s, input bit last_at_end, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], last_at_end && (i == s.len() - 1));
      if (gaps) repeat ($urandom_range(0, 2)) idle();
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_cmd_steps", 64'(cmd_steps), 64'd0);
    check("rst_cmd_count", 64'(cmd_count), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic finish_case(input string tag, input int exp_cmds, input int exp_errs, input bit exp_done);
    repeat (4) idle();
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_cmd_count"}, 64'(cmd_count), 64'(exp_cmds));
    check({tag, "_err_count"}, 64'(err_count), 64'(exp_errs));
    check({tag, "_done"}, 64'(done), 64'(exp_done));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(!exp_done));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Two basic commands, in_last on the final newline.
    exp_q.push_back({1'b1, 32'd68});
    exp_q.push_back({1'b0, 32'd48});
    send_str("L68\nR48\n", 1'b1, 1'b0);
    finish_case("basic", 2, 0, 1'b1);

    do_reset();
    exp_q.push_back({1'b1, 32'd5});
    exp_q.push_back({1'b0, 32'd0});
    send_str("\r\nL5\r\n\nR0\r\n", 1'b0, 1'b1);
    finish_case("crlf", 2, 0, 1'b0);

    // No trailing newline: emit and done rise together.
    do_reset();
    exp_q.push_back({1'b0, 32'd14});
    send_str("R14", 1'b1, 1'b0);
    check("nonl_valid_with_done", 64'({cmd_valid, done}), 64'b11);
    finish_case("nonl", 1, 0, 1'b1);

    do_reset();
    exp_q.push_back({1'b0, 32'd7});
    send_str("X12\nL\nL3x9\nR7\n", 1'b0, 1'b0);
    finish_case("malformed", 1, 3, 1'b0);

    do_reset();
    exp_q.push_back({1'b0, 32'hFFFF_FFFF});
    send_str("R4294967295\nR4294967296\n", 1'b0, 1'b0);
    finish_case("overflow", 1, 1, 1'b0);

    // Leading zeros, then a bare 'L' as the last byte is an error.
    do_reset();
    exp_q.push_back({1'b0, 32'd7});
    send_str("R007\nL", 1'b1, 1'b0);
    finish_case("lead0", 1, 1, 1'b1);

    do_reset();
    send_str("L12", 1'b0, 1'b0);
    do_reset();
    exp_q.push_back({1'b1, 32'd3});
    send_str("L3\n", 1'b0, 1'b0);
    finish_case("midrst", 1, 0, 1'b0);

    // AoC example through a behavioural dial starting at 50.
    do_reset();
    dial_pos   = 50;
    dial_zeros = 0;
    exp_q.push_back({1'b1, 32'd68});
    exp_q.push_back({1'b1, 32'd30});
    exp_q.push_back({1'b0, 32'd48});
    exp_q.push_back({1'b1, 32'd5});
    exp_q.push_back({1'b0, 32'd60});
    exp_q.push_back({1'b1, 32'd55});
    exp_q.push_back({1'b1, 32'd1});
    exp_q.push_back({1'b1, 32'd99});
    exp_q.push_back({1'b0, 32'd14});
    exp_q.push_back({1'b1, 32'd82});
    send_str("L68\nL30\nR48\nL5\nR60\nL55\nL1\nL99\nR14\nL82\n", 1'b1, 1'b0);
    finish_case("aoc", 10, 0, 1'b1);
    check("aoc_pos", 64'(dial_pos), 64'd32);
    check("aoc_zero_count", 64'(dial_zeros), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
